// File: rtl/traffic_pkg.sv
// Shared lamp codes, default durations and BCD / seven-segment helpers
// for the traffic countdown display.
package traffic_pkg;

  // Lamp codes as driven by the controller, bit order [R G Y]
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_G = 3'b010;
  localparam logic [2:0] LAMP_Y = 3'b001;

  // Default phase durations in seconds. Red covers the other direction's
  // green plus yellow.
  localparam int unsigned T_RED_DEF   = 30;
  localparam int unsigned T_GREEN_DEF = 25;
  localparam int unsigned T_YEL_DEF   = 5;

  // Result of decoding one lamp code
  typedef struct packed {
    logic       valid;
    logic [7:0] dur_bcd;
  } lamp_info_t;

  // Converts a 0..99 binary constant into packed {tens,units} BCD.
  // Only used on parameters, so it folds away at elaboration.
  function automatic logic [7:0] bin2bcd8(input int unsigned value);
    int unsigned tens;
    int unsigned units;
    tens  = value / 10;
    units = value % 10;
    return {tens[3:0], units[3:0]};
  endfunction

  // BCD digit to segments {g,f,e,d,c,b,a}, active-high; non-decimal codes stay dark
  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] segs;
    case (digit)
      4'd0:    segs = 7'h3F;
      4'd1:    segs = 7'h06;
      4'd2:    segs = 7'h5B;
      4'd3:    segs = 7'h4F;
      4'd4:    segs = 7'h66;
      4'd5:    segs = 7'h6D;
      4'd6:    segs = 7'h7D;
      4'd7:    segs = 7'h07;
      4'd8:    segs = 7'h7F;
      4'd9:    segs = 7'h6F;
      default: segs = 7'h00;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down-counter. A load always beats a decrement, and the
// count sticks at 00 instead of wrapping to 99.
module bcd_down_counter
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] bcd
);

  logic [7:0] bcd_d;
  logic [7:0] bcd_q;

  // Next count: load first, otherwise a borrow-aware decrement that stops at 00
  always_comb begin
    bcd_d = bcd_q;
    if (load) begin
      bcd_d = load_val;
    end else if (dec && (bcd_q != 8'h00)) begin
      if (bcd_q[3:0] == 4'd0) begin
        bcd_d = {bcd_q[7:4] - 4'd1, 4'd9};
      end else begin
        bcd_d = {bcd_q[7:4], bcd_q[3:0] - 4'd1};
      end
    end
  end

  // Count register, cleared by the active-low asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_q <= 8'h00;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/traffic_countdown_display.sv
// Countdown display for both directions of a traffic light. It watches the
// lamp codes, reloads a per-lamp duration on every change, counts down on
// the second strobe and scans the four digits onto a shared 7-segment bus.
module traffic_countdown_display
  import traffic_pkg::*;
#(
  parameter int unsigned T_RED    = T_RED_DEF,
  parameter int unsigned T_GREEN  = T_GREEN_DEF,
  parameter int unsigned T_YEL    = T_YEL_DEF,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic [7:0] a_bcd,
  output logic [7:0] b_bcd,
  output logic       a_blank,
  output logic       b_blank,
  output logic [6:0] seg,
  output logic [3:0] an
);

  // Durations must fit in two BCD digits and the scan slot must last at least two clocks
  if ((T_RED < 1) || (T_RED > 99) || (T_GREEN < 1) || (T_GREEN > 99) ||
      (T_YEL < 1) || (T_YEL > 99) || (SCAN_DIV < 2)) begin : g_param_check
    $error("traffic_countdown_display: illegal duration or scan parameter");
  end

  localparam logic [7:0] RED_BCD   = bin2bcd8(T_RED);
  localparam logic [7:0] GREEN_BCD = bin2bcd8(T_GREEN);
  localparam logic [7:0] YEL_BCD   = bin2bcd8(T_YEL);

  localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // Maps a lamp code to its duration; anything that is not exactly one lamp is invalid
  function automatic lamp_info_t decode_lamp(input logic [2:0] code);
    lamp_info_t info;
    info.valid   = 1'b1;
    info.dur_bcd = 8'h00;
    case (code)
      LAMP_R:  info.dur_bcd = RED_BCD;
      LAMP_G:  info.dur_bcd = GREEN_BCD;
      LAMP_Y:  info.dur_bcd = YEL_BCD;
      default: info.valid   = 1'b0;
    endcase
    return info;
  endfunction

  logic [2:0]        prev_a_q, prev_b_q;
  logic              a_blank_d, a_blank_q;
  logic              b_blank_d, b_blank_q;
  logic [SCAN_W-1:0] scan_cnt_d, scan_cnt_q;
  logic [3:0]        an_d, an_q;
  logic [6:0]        seg_d, seg_q;

  lamp_info_t a_info, b_info;
  logic       a_change, b_change;
  logic [7:0] a_count, b_count;

  // Decode both lamp codes and flag a change against last cycle's code
  always_comb begin
    a_info   = decode_lamp(A);
    b_info   = decode_lamp(B);
    a_change = (A != prev_a_q);
    b_change = (B != prev_b_q);
  end

  // A change loads a fresh count (00 for an invalid code); the counter gives the load priority over the tick
  bcd_down_counter u_cnt_a (
    .clk      (clk),
    .rst      (rst),
    .load     (a_change),
    .load_val (a_info.dur_bcd),
    .dec      (sec_tick),
    .bcd      (a_count)
  );

  bcd_down_counter u_cnt_b (
    .clk      (clk),
    .rst      (rst),
    .load     (b_change),
    .load_val (b_info.dur_bcd),
    .dec      (sec_tick),
    .bcd      (b_count)
  );

  // Blank follows the validity of the code at its most recent change
  always_comb begin
    a_blank_d = a_blank_q;
    b_blank_d = b_blank_q;
    if (a_change) begin
      a_blank_d = !a_info.valid;
    end
    if (b_change) begin
      b_blank_d = !b_info.valid;
    end
  end

  // Scan divider: hold each digit for SCAN_DIV clocks, then rotate the enable to the next digit
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    an_d       = an_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      an_d       = {an_q[0], an_q[3:1]};
    end
  end

  // Segments for the digit enabled next cycle, so seg and an change together
  always_comb begin
    seg_d = 7'h00;
    case (an_d)
      4'b1000: begin
        if (!a_blank_q && (a_count[7:4] != 4'd0)) begin
          seg_d = seg7_decode(a_count[7:4]);
        end
      end
      4'b0100: begin
        if (!a_blank_q) begin
          seg_d = seg7_decode(a_count[3:0]);
        end
      end
      4'b0010: begin
        if (!b_blank_q && (b_count[7:4] != 4'd0)) begin
          seg_d = seg7_decode(b_count[7:4]);
        end
      end
      4'b0001: begin
        if (!b_blank_q) begin
          seg_d = seg7_decode(b_count[3:0]);
        end
      end
      default: seg_d = 7'h00;
    endcase
  end

  // Registers for change detection, blank flags and the scan outputs.
  // prev resets to 000, so any valid code present at release reloads one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_a_q   <= 3'b000;
      prev_b_q   <= 3'b000;
      a_blank_q  <= 1'b1;
      b_blank_q  <= 1'b1;
      scan_cnt_q <= '0;
      an_q       <= 4'b1000;
      seg_q      <= 7'h00;
    end else begin
      prev_a_q   <= A;
      prev_b_q   <= B;
      a_blank_q  <= a_blank_d;
      b_blank_q  <= b_blank_d;
      scan_cnt_q <= scan_cnt_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign a_bcd   = a_count;
  assign b_bcd   = b_count;
  assign a_blank = a_blank_q;
  assign b_blank = b_blank_q;
  assign an      = an_q;
  assign seg     = seg_q;

endmodule

// File: tb/tb_traffic_countdown_display.sv
// Bench for traffic_countdown_display with a fast scan (4 clocks per digit).
// A seconds-level model of both directions runs alongside the DUT. It is
// checked every cycle, and the bench adds a vector table and hand-written
// corner sequences on top of that.
module tb_traffic_countdown_display;

  localparam int SCAN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic [2:0] a_in = 3'b000;
  logic [2:0] b_in = 3'b000;
  logic [7:0] a_bcd, b_bcd;
  logic       a_blank, b_blank;
  logic [6:0] seg;
  logic [3:0] an;

  traffic_countdown_display #(
    .T_RED    (30),
    .T_GREEN  (25),
    .T_YEL    (5),
    .SCAN_DIV (SCAN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (sec_tick),
    .A        (a_in),
    .B        (b_in),
    .a_bcd    (a_bcd),
    .b_bcd    (b_bcd),
    .a_blank  (a_blank),
    .b_blank  (b_blank),
    .seg      (seg),
    .an       (an)
  );

  // Free-running clock
  initial forever #5 clk = ~clk;

  localparam logic [6:0] DIGIT_SEGS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: remaining seconds per direction as plain integers
  int         m_a_rem, m_b_rem;
  bit         m_a_blank, m_b_blank;
  logic [2:0] m_prev_a, m_prev_b;
  int         m_clocks;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       tick;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_a_blank;
    logic       exp_b_blank;
  } vec_t;

  vec_t vecs [16];

  // Seconds for a lamp code, or -1 when the code is not a single lamp
  function automatic int lamp_seconds(input logic [2:0] code);
    if (code == 3'b100) return 30;
    if (code == 3'b010) return 25;
    if (code == 3'b001) return 5;
    return -1;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  // Segments for slot 0..3 (A tens, A units, B tens, B units), with blanking and leading-zero suppression
  function automatic logic [6:0] slot_segs(input int slot, input int arem, input bit ablank,
                                           input int brem, input bit bblank);
    int  rem;
    bit  blank;
    bit  tens;
    int  digit;
    rem   = (slot < 2) ? arem : brem;
    blank = (slot < 2) ? ablank : bblank;
    tens  = (slot % 2) == 0;
    digit = tens ? rem / 10 : rem % 10;
    if (blank || (tens && digit == 0)) return 7'h00;
    return DIGIT_SEGS[digit];
  endfunction

  task automatic model_direction(input logic [2:0] code, inout logic [2:0] prev,
                                 input bit tick, inout int rem, inout bit blank);
    int secs;
    secs = lamp_seconds(code);
    if (code != prev) begin
      rem   = (secs < 0) ? 0 : secs;
      blank = (secs < 0);
    end else if (tick && rem > 0) begin
      rem = rem - 1;
    end
    prev = code;
  endtask

  // One rising edge worth of model: the display shows the values from before the edge
  task automatic model_step(input logic [2:0] a, input logic [2:0] b, input bit tick);
    int slot;
    m_clocks = m_clocks + 1;
    slot     = (m_clocks / SCAN) % 4;
    m_an     = 4'b1000 >> slot;
    m_seg    = slot_segs(slot, m_a_rem, m_a_blank, m_b_rem, m_b_blank);
    model_direction(a, m_prev_a, tick, m_a_rem, m_a_blank);
    model_direction(b, m_prev_b, tick, m_b_rem, m_b_blank);
  endtask

  task automatic model_reset();
    m_a_rem   = 0;
    m_b_rem   = 0;
    m_a_blank = 1'b1;
    m_b_blank = 1'b1;
    m_prev_a  = 3'b000;
    m_prev_b  = 3'b000;
    m_clocks  = 0;
    m_an      = 4'b1000;
    m_seg     = 7'h00;
  endtask

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Compare every output against the model
  task automatic checkOutput();
    cmp("a_bcd", a_bcd, to_bcd(m_a_rem));
    cmp("b_bcd", b_bcd, to_bcd(m_b_rem));
    cmp("a_blank", {7'd0, a_blank}, {7'd0, m_a_blank});
    cmp("b_blank", {7'd0, b_blank}, {7'd0, m_b_blank});
    cmp("an", {4'd0, an}, {4'd0, m_an});
    cmp("seg", {1'b0, seg}, {1'b0, m_seg});
  endtask

  // Drive one cycle of inputs, clock it, advance the model and check after the edge
  task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input logic tick);
    a_in     = a;
    b_in     = b;
    sec_tick = tick;
    @(posedge clk);
    model_step(a, b, tick);
    #1;
    checkOutput();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic doReset();
    rst = 1'b0;
    #1;
    cmp("rst_a_bcd", a_bcd, 8'h00);
    cmp("rst_b_bcd", b_bcd, 8'h00);
    cmp("rst_a_blank", {7'd0, a_blank}, 8'h01);
    cmp("rst_b_blank", {7'd0, b_blank}, 8'h01);
    cmp("rst_an", {4'd0, an}, 8'h08);
    cmp("rst_seg", {1'b0, seg}, 8'h00);
    model_reset();
    #3;
    rst = 1'b1;
  endtask

  // Hold the inputs until the wanted digit is enabled, then check its segments
  task automatic waitSlot(input logic [3:0] target, input logic [6:0] want, input string name);
    int n;
    n = 0;
    applyStimulus(a_in, b_in, 1'b0);
    while (an !== target && n < 4 * SCAN + 4) begin
      applyStimulus(a_in, b_in, 1'b0);
      n++;
    end
    if (an !== target) begin
      cmp({name, "_timeout"}, {4'd0, an}, {4'd0, target});
    end else begin
      cmp(name, {1'b0, seg}, {1'b0, want});
    end
  endtask

  initial begin
    logic [2:0] codes [6];
    logic [2:0] ra, rb;
    codes = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b111, 3'b110};

    // Change/countdown/saturation, same-cycle load against tick, invalid code
    vecs[0]  = '{3'b001, 3'b100, 1'b0, 8'h05, 8'h30, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 3'b100, 1'b1, 8'h04, 8'h29, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 3'b100, 1'b1, 8'h03, 8'h28, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 3'b100, 1'b1, 8'h02, 8'h27, 1'b0, 1'b0};
    vecs[4]  = '{3'b001, 3'b100, 1'b1, 8'h01, 8'h26, 1'b0, 1'b0};
    vecs[5]  = '{3'b001, 3'b100, 1'b1, 8'h00, 8'h25, 1'b0, 1'b0};
    vecs[6]  = '{3'b001, 3'b100, 1'b1, 8'h00, 8'h24, 1'b0, 1'b0};
    vecs[7]  = '{3'b001, 3'b100, 1'b0, 8'h00, 8'h24, 1'b0, 1'b0};
    vecs[8]  = '{3'b010, 3'b100, 1'b0, 8'h25, 8'h24, 1'b0, 1'b0};
    vecs[9]  = '{3'b010, 3'b100, 1'b1, 8'h24, 8'h23, 1'b0, 1'b0};
    vecs[10] = '{3'b100, 3'b100, 1'b1, 8'h30, 8'h22, 1'b0, 1'b0};
    vecs[11] = '{3'b100, 3'b100, 1'b1, 8'h29, 8'h21, 1'b0, 1'b0};
    vecs[12] = '{3'b111, 3'b100, 1'b1, 8'h00, 8'h20, 1'b1, 1'b0};
    vecs[13] = '{3'b111, 3'b100, 1'b1, 8'h00, 8'h19, 1'b1, 1'b0};
    vecs[14] = '{3'b111, 3'b100, 1'b0, 8'h00, 8'h19, 1'b1, 1'b0};
    vecs[15] = '{3'b010, 3'b100, 1'b0, 8'h25, 8'h19, 1'b0, 1'b0};

    #2;
    doReset();
    applyStimulus(3'b000, 3'b000, 1'b0);

    $display("[TB] vector table");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].tick);
      cmp($sformatf("vec%0d_a_bcd", i), a_bcd, vecs[i].exp_a);
      cmp($sformatf("vec%0d_b_bcd", i), b_bcd, vecs[i].exp_b);
      cmp($sformatf("vec%0d_a_blank", i), {7'd0, a_blank}, {7'd0, vecs[i].exp_a_blank});
      cmp($sformatf("vec%0d_b_blank", i), {7'd0, b_blank}, {7'd0, vecs[i].exp_b_blank});
    end

    $display("[TB] reset in the middle of a count, red countdown through 10 -> 09");
    applyStimulus(3'b010, 3'b100, 1'b1);
    doReset();
    applyStimulus(3'b000, 3'b100, 1'b0);
    cmp("b_red_load", b_bcd, 8'h30);
    for (int i = 1; i <= 21; i++) begin
      applyStimulus(3'b000, 3'b100, 1'b1);
      cmp($sformatf("b_red_tick%0d", i), b_bcd, to_bcd(30 - i));
    end
    waitSlot(4'b0010, 7'h00, "b_tens_leading_zero");
    waitSlot(4'b0001, 7'h6F, "b_units_9");
    waitSlot(4'b1000, 7'h00, "a_tens_blank");
    waitSlot(4'b0100, 7'h00, "a_units_blank");

    $display("[TB] scan of 25 / 05");
    doReset();
    applyStimulus(3'b010, 3'b001, 1'b0);
    waitSlot(4'b1000, 7'h5B, "scan_a_tens_2");
    waitSlot(4'b0100, 7'h6D, "scan_a_units_5");
    waitSlot(4'b0010, 7'h00, "scan_b_tens_0");
    waitSlot(4'b0001, 7'h6D, "scan_b_units_5");

    $display("[TB] random lamp sequences");
    ra = 3'b010;
    rb = 3'b100;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) ra = codes[$urandom_range(0, 5)];
      if ($urandom_range(0, 19) == 0) rb = codes[$urandom_range(0, 5)];
      applyStimulus(ra, rb, 1'($urandom_range(0, 9) < 4));
      if (i == 300) doReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
